mmu_seq: RTL

MMU_SEQ -- requirements
Module: mmu_seq

---
 rtl/mmu_seq_if.sv | 45 ++++
 rtl/mmu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mmu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mmu_seq_if
// Description : Command, MMU handshake and status bundle for the MMU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmu_seq_if #(
  parameter int OUT_FIFO_DEPTH = 8
) ();
  localparam int PW = $clog2(OUT_FIFO_DEPTH + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          weight_ld_rdy;
  logic          weight_ld_start;
  logic          weight_ld_done;
  logic          weight_swap;
  logic          mult_rdy;
  logic          mult_start;
  logic          mult_done;
  logic          acc_pop;
  logic          busy;
  logic          staged;
  logic [PW-1:0] pending;
  logic          err;
  logic [1:0]    err_code;
  logic          err_clr;

  // master is the sequencer side, slave is the command source / MMU side
  modport master (
    input  cmd_valid, cmd_op, weight_ld_rdy, weight_ld_done, mult_rdy,
           mult_done, acc_pop, err_clr,
    output cmd_ready, weight_ld_start, weight_swap, mult_start, busy,
           staged, pending, err, err_code
  );

  modport slave (
    output cmd_valid, cmd_op, weight_ld_rdy, weight_ld_done, mult_rdy,
           mult_done, acc_pop, err_clr,
    input  cmd_ready, weight_ld_start, weight_swap, mult_start, busy,
           staged, pending, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/mmu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mmu_seq
// Description : Command sequencer for an MMU: weight load/swap, multiply with
//               result-credit tracking, wait timeouts and sticky error status.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_seq #(
  parameter int OUT_FIFO_DEPTH = 8,
  parameter int TIMEOUT        = 1024
) (
  input  logic      clk,
  input  logic      rst_n,
  mmu_seq_if.master bus
);
  localparam int PW = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] c_DEPTH     = PW'(OUT_FIFO_DEPTH);
  localparam logic [WW-1:0] c_WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_REQ   = 3'd1,
    S_LD_WAIT  = 3'd2,
    S_SWAP     = 3'd3,
    S_MUL_REQ  = 3'd4,
    S_MUL_WAIT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          staged_q, staged_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          w_raise;
  logic [1:0]    w_raise_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      staged_q   <= 1'b0;
      pending_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      staged_q   <= staged_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    wait_d              = wait_q;
    staged_d            = staged_q;
    bus.cmd_ready       = 1'b0;
    bus.busy            = 1'b1;
    bus.weight_ld_start = 1'b0;
    bus.weight_swap     = 1'b0;
    bus.mult_start      = 1'b0;
    w_raise             = 1'b0;
    w_raise_code        = 2'd0;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            2'd1:    state_d = S_LD_REQ;
            2'd2:    state_d = S_SWAP;
            2'd3:    state_d = S_MUL_REQ;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LD_REQ: begin
        if (bus.weight_ld_rdy) begin
          bus.weight_ld_start = 1'b1;
          wait_d              = '0;
          state_d             = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        // a done in the last wait cycle still counts as success
        if (bus.weight_ld_done) begin
          staged_d = 1'b1;
          state_d  = S_IDLE;
        end else if (wait_q == c_WAIT_LAST) begin
          w_raise      = 1'b1;
          w_raise_code = 2'd2;
          state_d      = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_SWAP: begin
        bus.weight_swap = staged_q;
        if (!staged_q) begin
          w_raise      = 1'b1;
          w_raise_code = 2'd1;
        end
        staged_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_MUL_REQ: begin
        if (bus.mult_rdy && (pending_q < c_DEPTH)) begin
          bus.mult_start = 1'b1;
          wait_d         = '0;
          state_d        = S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (bus.mult_done) begin
          state_d = S_IDLE;
        end else if (wait_q == c_WAIT_LAST) begin
          w_raise      = 1'b1;
          w_raise_code = 2'd3;
          state_d      = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // result credits track every mult_done, whatever state the FSM is in
  always_comb begin
    pending_d = pending_q;
    if (bus.mult_done && !bus.acc_pop) begin
      if (pending_q != c_DEPTH) pending_d = pending_q + PW'(1);
    end else if (!bus.mult_done && bus.acc_pop && (pending_q != '0)) begin
      pending_d = pending_q - PW'(1);
    end
  end

  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (bus.err_clr) begin
      err_d      = 1'b0;
      err_code_d = 2'd0;
    end
    // first error is kept; a clear in the same cycle lets the new one in
    if (w_raise) begin
      err_d = 1'b1;
      if (!err_q || bus.err_clr) err_code_d = w_raise_code;
    end
  end

  assign bus.staged   = staged_q;
  assign bus.pending  = pending_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
endmodule
`default_nettype wire
